// File: rtl/mtl2_sw_pkg.sv
// Shared types and defaults for the MTL2 switch poller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default switch width / poll divider, switch data register offset.
package mtl2_sw_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EVAL = 2'd2
   } state_t;

   localparam int SW_W_DEF     = 4;
   localparam int POLL_DIV_DEF = 50000;
   localparam int SW_DATA_OFS  = 0;

endpackage

// File: rtl/mtl2_sw_debounce.sv
// Debounce filter: a sample is committed once STABLE_CNT consecutive equal samples are seen.
// Latency: combinational commit decision in the strobe cycle; cand/sc update on the following edge.
// Backpressure: none; one evaluation per samp_stb pulse.
// Ports: clk, reset_n (sync, active-low); samp + samp_stb (new sample); sw_state/sw_valid
//        (current committed value from the top); commit (one-cycle strobe) and commit_val.
// Only instantiated when MTL2_SW_POLL_DEBOUNCE_EN is defined.
module mtl2_sw_debounce #(
   parameter int SW_W       = 4,
   parameter int STABLE_CNT = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [SW_W-1:0] samp,
   input  logic            samp_stb,
   input  logic [SW_W-1:0] sw_state,
   input  logic            sw_valid,
   output logic            commit,
   output logic [SW_W-1:0] commit_val
);

   localparam int SC_W = $clog2(STABLE_CNT + 1);

   logic [SW_W-1:0] cand, cand_nxt;
   logic [SC_W-1:0] sc, sc_nxt;

   // sc saturates at STABLE_CNT so a long-stable input never wraps back below the threshold.
   always_comb begin
      cand_nxt = cand;
      sc_nxt   = sc;
      if (samp_stb) begin
         if (samp != cand) begin
            cand_nxt = samp;
            sc_nxt   = SC_W'(1);
         end else if (sc < SC_W'(STABLE_CNT)) begin
            sc_nxt = sc + 1'b1;
         end
      end
   end

   // Decision uses the updated counter, so the STABLE_CNT-th equal sample commits in this cycle.
   assign commit_val = cand_nxt;
   assign commit     = samp_stb && (sc_nxt >= SC_W'(STABLE_CNT)) &&
                       ((cand_nxt != sw_state) || !sw_valid);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cand <= '0;
         sc   <= '0;
      end else begin
         cand <= cand_nxt;
         sc   <= sc_nxt;
      end
   end

endmodule

// File: rtl/mtl2_sw_poller.sv
// Avalon-MM master polling the MTL2 switch PIO; produces committed switch state and change/rise/fall pulses.
// Latency: accept cycle T, evaluation at T+1, sw_state and pulses visible at T+2; poll period POLL_DIV+2+waits.
// Backpressure: avm_read/avm_address held stable while avm_waitrequest=1; reads are never aborted.
// Ports: clk, reset_n (sync, active-low); avm_address/avm_read out, avm_waitrequest/avm_readdata in;
//        sw_state, sw_valid, sw_changed, sw_rise, sw_fall out.
// Option: MTL2_SW_POLL_DEBOUNCE_EN enables the mtl2_sw_debounce filter; otherwise every differing sample commits.
module mtl2_sw_poller
   import mtl2_sw_pkg::*;
#(
   parameter int SW_W       = SW_W_DEF,
   parameter int ADDR_W     = 2,
   parameter int BASE_ADDR  = SW_DATA_OFS,
   parameter int POLL_DIV   = POLL_DIV_DEF,
   parameter int STABLE_CNT = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   output logic [SW_W-1:0]   sw_state,
   output logic              sw_valid,
   output logic              sw_changed,
   output logic [SW_W-1:0]   sw_rise,
   output logic [SW_W-1:0]   sw_fall
);

   localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept;
   logic             eval;
   logic [SW_W-1:0]  samp;
   logic             commit;
   logic [SW_W-1:0]  commit_val;

   // Upper data bits carry other PIO content and are deliberately dropped.
   logic unused_rdata;
   assign unused_rdata = ^avm_readdata[31:SW_W];

   assign avm_address = ADDR_W'(BASE_ADDR);
   assign avm_read    = (state == READ);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // cnt starts at 0 so the first read is issued right after reset release.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      eval      = 1'b0;
      case (state)
         IDLE: begin
            if (cnt == '0) begin
               state_nxt = READ;
               cnt_nxt   = CNT_W'(POLL_DIV - 1);
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         READ: begin
            if (!avm_waitrequest) begin
               accept    = 1'b1;
               state_nxt = EVAL;
            end
         end
         EVAL: begin
            eval      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MTL2_SW_POLL_DEBOUNCE_EN
   mtl2_sw_debounce #(
      .SW_W       (SW_W),
      .STABLE_CNT (STABLE_CNT)
   ) u_debounce (
      .clk        (clk),
      .reset_n    (reset_n),
      .samp       (samp),
      .samp_stb   (eval),
      .sw_state   (sw_state),
      .sw_valid   (sw_valid),
      .commit     (commit),
      .commit_val (commit_val)
   );
`else
   // Without the filter the stability threshold has no meaning.
   logic unused_stable_cnt;
   assign unused_stable_cnt = (STABLE_CNT > 0);

   assign commit     = eval && ((samp != sw_state) || !sw_valid);
   assign commit_val = samp;
`endif

   // Pulses default low every cycle; the first commit after reset only raises sw_valid.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt        <= '0;
         samp       <= '0;
         sw_state   <= '0;
         sw_valid   <= 1'b0;
         sw_changed <= 1'b0;
         sw_rise    <= '0;
         sw_fall    <= '0;
      end else begin
         cnt        <= cnt_nxt;
         sw_changed <= 1'b0;
         sw_rise    <= '0;
         sw_fall    <= '0;
         if (accept) begin
            samp <= avm_readdata[SW_W-1:0];
         end
         if (commit) begin
            sw_state <= commit_val;
            sw_valid <= 1'b1;
            if (sw_valid) begin
               sw_changed <= 1'b1;
               sw_rise    <= commit_val & ~sw_state;
               sw_fall    <= ~commit_val & sw_state;
            end
         end
      end
   end

endmodule
